// File: rtl/invaders_pkg.sv
// Shared types and constants for the Space Invaders playfield blocks.
// Bullet defaults live here so color_mapper and collision logic agree on geometry.
package invaders_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MOVE,
    SPAWN
  } bullet_state_t;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  localparam int DEF_NUM_BULLETS   = 4;
  localparam int DEF_BULLET_SPEED  = 4;
  localparam int DEF_BULLET_W      = 2;
  localparam int DEF_BULLET_H      = 8;
  localparam int DEF_Y_MIN         = 0;
  localparam int DEF_FIRE_COOLDOWN = 8;

endpackage

// File: rtl/bullet_pixel_match.sv
// Single-slot rectangle hit test: is (draw_x, draw_y) inside this active bullet?
// Compares run in 11 bits so x+W-1 / y+H-1 cannot wrap at the screen edge.
module bullet_pixel_match #(
  parameter int BULLET_W = 2,
  parameter int BULLET_H = 8
) (
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       active,
  input  logic [9:0] draw_x,
  input  logic [9:0] draw_y,
  output logic       match
);

  logic [10:0] x_lo, x_hi, y_lo, y_hi, dx, dy;

  assign x_lo = {1'b0, x};
  assign y_lo = {1'b0, y};
  assign x_hi = x_lo + 11'(BULLET_W - 1);
  assign y_hi = y_lo + 11'(BULLET_H - 1);
  assign dx   = {1'b0, draw_x};
  assign dy   = {1'b0, draw_y};

  assign match = active && (dx >= x_lo) && (dx <= x_hi) && (dy >= y_lo) && (dy <= y_hi);

endmodule

// File: rtl/bullet_controller.sv
// Player-bullet slot owner: latches fire, walks every slot once per frame
// (MOVE), then tries a single spawn (SPAWN). Pixel lookup is purely combinational.
module bullet_controller
  import invaders_pkg::*;
#(
  parameter int NUM_BULLETS   = DEF_NUM_BULLETS,
  parameter int BULLET_SPEED  = DEF_BULLET_SPEED,
  parameter int BULLET_W      = DEF_BULLET_W,
  parameter int BULLET_H      = DEF_BULLET_H,
  parameter int Y_MIN         = DEF_Y_MIN,
  parameter int FIRE_COOLDOWN = DEF_FIRE_COOLDOWN,
  localparam int IDXW = $clog2(NUM_BULLETS)
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      frame_clk,
  input  logic                      fire,
  input  logic [9:0]                PlayerX,
  input  logic [9:0]                PlayerY,
  input  logic                      hit_valid,
  input  logic [IDXW-1:0]           hit_idx,
  input  logic [9:0]                DrawX,
  input  logic [9:0]                DrawY,
  output logic                      bullet_on,
  output logic [IDXW-1:0]           bullet_idx,
  output logic [NUM_BULLETS-1:0]    active_mask,
  output logic [10*NUM_BULLETS-1:0] bulletX_flat,
  output logic [10*NUM_BULLETS-1:0] bulletY_flat,
  output logic                      busy
);

  localparam int CDW = $clog2(FIRE_COOLDOWN + 1);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_BULLETS - 1);

  bullet_state_t state, next_state;
  logic [IDXW-1:0] idx, idx_next;
  logic [CDW-1:0]  cooldown;
  logic            frame_q, fire_pend, tick;

  logic [NUM_BULLETS-1:0] active;
  logic [9:0]             pos_x [NUM_BULLETS];
  logic [9:0]             pos_y [NUM_BULLETS];

  logic            free_found, can_spawn, retire, hit_here;
  logic [IDXW-1:0] free_idx;

  assign tick = frame_clk & ~frame_q;
  assign busy = (state != IDLE);

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    idx_next   = idx;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
      if (!active[i]) begin
        free_found = 1'b1;
        free_idx   = IDXW'(i);
      end
    end
    can_spawn = fire_pend && free_found && ({1'b0, PlayerY} >= 11'(Y_MIN + BULLET_H));
    retire    = active[idx] && ({1'b0, pos_y[idx]} < 11'(Y_MIN + BULLET_SPEED));
    hit_here  = hit_valid && (hit_idx == idx);
    unique case (state)
      IDLE: if (tick) begin
        next_state = MOVE;
        idx_next   = '0;
      end
      MOVE: begin
        if (idx == LAST_IDX) next_state = SPAWN;
        else                 idx_next   = idx + 1'b1;
      end
      SPAWN:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= next_state;
      idx   <= idx_next;
    end
  end

  // NOTE: the slot arrays are reset because their contents drive output ports that must read 0 after reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_q   <= 1'b0;
      fire_pend <= 1'b0;
      cooldown  <= '0;
      active    <= '0;
      for (int i = 0; i < NUM_BULLETS; i++) begin
        pos_x[i] <= '0;
        pos_y[i] <= '0;
      end
    end else begin
      frame_q <= frame_clk;
      if (fire) fire_pend <= 1'b1;
      // A hit on the slot being moved wins: it is cleared below and keeps its Y.
      if (state == MOVE && active[idx]) begin
        if (retire)         active[idx] <= 1'b0;
        else if (!hit_here) pos_y[idx]  <= pos_y[idx] - 10'(BULLET_SPEED);
      end
      if (state == SPAWN) begin
        fire_pend <= 1'b0;
        if (cooldown != '0) begin
          cooldown <= cooldown - 1'b1;
        end else if (can_spawn) begin
          active[free_idx] <= 1'b1;
          pos_x[free_idx]  <= PlayerX;
          pos_y[free_idx]  <= PlayerY - 10'(BULLET_H);
          cooldown         <= CDW'(FIRE_COOLDOWN);
        end
      end
      // Only currently-active slots are cleared, so a same-cycle spawn is never undone.
      if (hit_valid && active[hit_idx]) active[hit_idx] <= 1'b0;
    end
  end

  logic [NUM_BULLETS-1:0] match;

  for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_slot
    bullet_pixel_match #(
      .BULLET_W(BULLET_W),
      .BULLET_H(BULLET_H)
    ) u_match (
      .x      (pos_x[g]),
      .y      (pos_y[g]),
      .active (active[g]),
      .draw_x (DrawX),
      .draw_y (DrawY),
      .match  (match[g])
    );
    assign bulletX_flat[10*g +: 10] = pos_x[g];
    assign bulletY_flat[10*g +: 10] = pos_y[g];
  end

  always_comb begin
    bullet_on  = |match;
    bullet_idx = '0;
    for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
      if (match[i]) bullet_idx = IDXW'(i);
    end
  end

  assign active_mask = active;

endmodule

// File: tb/tb_bullet_controller.sv
// Directed bench for bullet_controller: spawn, cooldown, retirement, hits,
// full-slot behaviour, pixel lookup and mid-sequence reset.
module tb_bullet_controller;

  localparam int N = 4;

  logic          Clk = 1'b0;
  logic          Reset, frame_clk, fire, hit_valid;
  logic [1:0]    hit_idx;
  logic [9:0]    PlayerX, PlayerY, DrawX, DrawY;
  logic          bullet_on, busy;
  logic [1:0]    bullet_idx;
  logic [N-1:0]  active_mask;
  logic [10*N-1:0] bulletX_flat, bulletY_flat;

  int vectors = 0;
  int miscompares = 0;

  bullet_controller dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .frame_clk    (frame_clk),
    .fire         (fire),
    .PlayerX      (PlayerX),
    .PlayerY      (PlayerY),
    .hit_valid    (hit_valid),
    .hit_idx      (hit_idx),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .bullet_on    (bullet_on),
    .bullet_idx   (bullet_idx),
    .active_mask  (active_mask),
    .bulletX_flat (bulletX_flat),
    .bulletY_flat (bulletY_flat),
    .busy         (busy)
  );

  always #5 Clk = ~Clk;

  function automatic logic [9:0] slot_x(input int i);
    return bulletX_flat[10*i +: 10];
  endfunction

  function automatic logic [9:0] slot_y(input int i);
    return bulletY_flat[10*i +: 10];
  endfunction

  task automatic apply_reset();
    @(negedge Clk);
    Reset = 1'b1; frame_clk = 1'b0; fire = 1'b0; hit_valid = 1'b0; hit_idx = '0;
    PlayerX = '0; PlayerY = '0; DrawX = '0; DrawY = '0;
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic pulse_fire();
    @(negedge Clk) fire = 1'b1;
    @(negedge Clk) fire = 1'b0;
  endtask

  task automatic idle_hit(input logic [1:0] idx);
    @(negedge Clk) begin hit_valid = 1'b1; hit_idx = idx; end
    @(negedge Clk) hit_valid = 1'b0;
  endtask

  // One frame edge; optionally injects a hit during busy cycle hit_at+1 (slot hit_at in MOVE).
  task automatic run_frame(input bit do_hit, input int hit_at, input logic [1:0] hidx);
    int cnt = 0;
    @(negedge Clk) frame_clk = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge Clk);
      hit_valid = 1'b0;
      if (busy) begin
        cnt++;
        if (do_hit && cnt == hit_at + 1) begin hit_valid = 1'b1; hit_idx = hidx; end
      end else if (cnt > 0) begin
        break;
      end
    end
    frame_clk = 1'b0;
    hit_valid = 1'b0;
    vectors++;
    if (cnt != N + 1) begin
      miscompares++;
      $display("FAIL busy_len: got %0d cycles, want %0d", cnt, N + 1);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++;
    if (active_mask !== 4'b0 || busy !== 1'b0 || bullet_on !== 1'b0 || bullet_idx !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_ctrl: mask=%b busy=%b on=%b idx=%0d, want all 0", active_mask, busy, bullet_on, bullet_idx);
    end
    vectors++;
    if (bulletX_flat !== '0 || bulletY_flat !== '0) begin
      miscompares++;
      $display("FAIL reset_pos: x=%h y=%h, want 0", bulletX_flat, bulletY_flat);
    end
  endtask

  task automatic test_spawn();
    apply_reset();
    PlayerX = 10'd320; PlayerY = 10'd440;
    pulse_fire();
    run_frame(0, 0, 2'd0);
    vectors++;
    if (active_mask !== 4'b0001 || slot_x(0) !== 10'd320 || slot_y(0) !== 10'd432) begin
      miscompares++;
      $display("FAIL spawn: mask=%b x=%0d y=%0d, want 0001 320 432", active_mask, slot_x(0), slot_y(0));
    end
    run_frame(0, 0, 2'd0);
    vectors++;
    if (active_mask !== 4'b0001 || slot_y(0) !== 10'd428) begin
      miscompares++;
      $display("FAIL move: mask=%b y=%0d, want 0001 428", active_mask, slot_y(0));
    end
  endtask

  task automatic test_reset_mid_move();
    int wait_cnt = 0;
    // Slot0 sits at (320,428) from the previous test; it moves to 424 in this frame.
    DrawX = 10'd320; DrawY = 10'd424;
    @(negedge Clk) frame_clk = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    vectors++;
    if (busy !== 1'b1 || bullet_on !== 1'b1 || bullet_idx !== 2'd0) begin
      miscompares++;
      $display("FAIL pre_reset: busy=%b on=%b idx=%0d, want 1 1 0", busy, bullet_on, bullet_idx);
    end
    Reset = 1'b1;
    @(negedge Clk);
    vectors++;
    if (active_mask !== 4'b0 || busy !== 1'b0 || bullet_on !== 1'b0 ||
        bulletX_flat !== '0 || bulletY_flat !== '0) begin
      miscompares++;
      $display("FAIL mid_reset: mask=%b busy=%b on=%b x=%h y=%h, want all 0",
               active_mask, busy, bullet_on, bulletX_flat, bulletY_flat);
    end
    Reset = 1'b0;
    @(negedge Clk);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL release_tick: busy=%b, want 1", busy);
    end
    while (busy && wait_cnt < 20) begin @(negedge Clk); wait_cnt++; end
    frame_clk = 1'b0;
    vectors++;
    if (busy !== 1'b0 || active_mask !== 4'b0) begin
      miscompares++;
      $display("FAIL release_frame: busy=%b mask=%b, want 0 0000", busy, active_mask);
    end
  endtask

  task automatic test_cooldown();
    logic [3:0] exp_mask;
    apply_reset();
    PlayerX = 10'd320; PlayerY = 10'd440;
    fire = 1'b1;
    for (int f = 1; f <= 12; f++) begin
      run_frame(0, 0, 2'd0);
      exp_mask = (f >= 10) ? 4'b0011 : 4'b0001;
      vectors++;
      if (active_mask !== exp_mask) begin
        miscompares++;
        $display("FAIL cooldown_f%0d: mask=%b, want %b", f, active_mask, exp_mask);
      end
    end
    fire = 1'b0;
    // Slot1 spawned at 432 in frame 10, moved in frames 11 and 12.
    vectors++;
    if (slot_y(1) !== 10'd424) begin
      miscompares++;
      $display("FAIL cooldown_y1: y=%0d, want 424", slot_y(1));
    end
  endtask

  task automatic test_retire();
    int n = 0;
    apply_reset();
    PlayerX = 10'd50; PlayerY = 10'd14;
    pulse_fire();
    run_frame(0, 0, 2'd0);
    vectors++;
    if (active_mask !== 4'b0001 || slot_y(0) !== 10'd6) begin
      miscompares++;
      $display("FAIL retire_spawn: mask=%b y=%0d, want 0001 6", active_mask, slot_y(0));
    end
    run_frame(0, 0, 2'd0);
    vectors++;
    if (active_mask !== 4'b0001 || slot_y(0) !== 10'd2) begin
      miscompares++;
      $display("FAIL retire_y2: mask=%b y=%0d, want 0001 2", active_mask, slot_y(0));
    end
    run_frame(0, 0, 2'd0);
    vectors++;
    if (active_mask !== 4'b0000 || slot_y(0) !== 10'd2 || slot_x(0) !== 10'd50) begin
      miscompares++;
      $display("FAIL retire_off: mask=%b x=%0d y=%0d, want 0000 50 2", active_mask, slot_x(0), slot_y(0));
    end
    // Cooldown reads 6 here; six more frames drain it, the seventh spawns.
    PlayerX = 10'd200; PlayerY = 10'd300;
    fire = 1'b1;
    do begin
      run_frame(0, 0, 2'd0);
      n++;
    end while (!active_mask[0] && n < 12);
    fire = 1'b0;
    vectors++;
    if (n != 7 || active_mask !== 4'b0001 || slot_x(0) !== 10'd200 || slot_y(0) !== 10'd292) begin
      miscompares++;
      $display("FAIL respawn: frames=%0d mask=%b x=%0d y=%0d, want 7 0001 200 292",
               n, active_mask, slot_x(0), slot_y(0));
    end
  endtask

  task automatic test_hit();
    apply_reset();
    fire = 1'b1;
    for (int f = 1; f <= 10; f++) begin
      PlayerX = (f == 10) ? 10'd60 : 10'd320;
      PlayerY = (f == 10) ? 10'd108 : 10'd440;
      run_frame(0, 0, 2'd0);
    end
    fire = 1'b0;
    vectors++;
    if (active_mask !== 4'b0011 || slot_y(1) !== 10'd100 || slot_y(0) !== 10'd396) begin
      miscompares++;
      $display("FAIL hit_setup: mask=%b y0=%0d y1=%0d, want 0011 396 100", active_mask, slot_y(0), slot_y(1));
    end
    idle_hit(2'd3);
    vectors++;
    if (active_mask !== 4'b0011) begin
      miscompares++;
      $display("FAIL hit_inactive: mask=%b, want 0011", active_mask);
    end
    run_frame(1, 1, 2'd1);
    vectors++;
    if (active_mask !== 4'b0001 || slot_y(1) !== 10'd100 || slot_x(1) !== 10'd60 || slot_y(0) !== 10'd392) begin
      miscompares++;
      $display("FAIL hit_vs_move: mask=%b x1=%0d y1=%0d y0=%0d, want 0001 60 100 392",
               active_mask, slot_x(1), slot_y(1), slot_y(0));
    end
  endtask

  task automatic test_full();
    apply_reset();
    fire = 1'b1;
    for (int f = 1; f <= 28; f++) begin
      PlayerX = (f == 19) ? 10'd100 : 10'd320;
      PlayerY = (f == 19) ? 10'd276 : 10'd440;
      run_frame(0, 0, 2'd0);
    end
    fire = 1'b0;
    vectors++;
    if (active_mask !== 4'b1111) begin
      miscompares++;
      $display("FAIL full_fill: mask=%b, want 1111", active_mask);
    end
    for (int f = 29; f <= 36; f++) run_frame(0, 0, 2'd0);
    vectors++;
    if (slot_x(2) !== 10'd100 || slot_y(2) !== 10'd200 || slot_y(0) !== 10'd292 || slot_y(3) !== 10'd400) begin
      miscompares++;
      $display("FAIL full_pos: x2=%0d y2=%0d y0=%0d y3=%0d, want 100 200 292 400",
               slot_x(2), slot_y(2), slot_y(0), slot_y(3));
    end
    DrawX = 10'd101; DrawY = 10'd207; #1;
    vectors++;
    if (bullet_on !== 1'b1 || bullet_idx !== 2'd2) begin
      miscompares++;
      $display("FAIL pix_corner: on=%b idx=%0d, want 1 2", bullet_on, bullet_idx);
    end
    DrawY = 10'd208; #1;
    vectors++;
    if (bullet_on !== 1'b0 || bullet_idx !== 2'd0) begin
      miscompares++;
      $display("FAIL pix_below: on=%b idx=%0d, want 0 0", bullet_on, bullet_idx);
    end
    DrawX = 10'd102; DrawY = 10'd207; #1;
    vectors++;
    if (bullet_on !== 1'b0) begin
      miscompares++;
      $display("FAIL pix_right: on=%b, want 0", bullet_on);
    end
    DrawX = 10'd100; DrawY = 10'd200; #1;
    vectors++;
    if (bullet_on !== 1'b1 || bullet_idx !== 2'd2) begin
      miscompares++;
      $display("FAIL pix_origin: on=%b idx=%0d, want 1 2", bullet_on, bullet_idx);
    end
    // Cooldown is 0 now; a fire with no free slot must not spawn and must be consumed.
    PlayerX = 10'd10; PlayerY = 10'd50;
    pulse_fire();
    run_frame(0, 0, 2'd0);
    vectors++;
    if (active_mask !== 4'b1111) begin
      miscompares++;
      $display("FAIL full_nospawn: mask=%b, want 1111", active_mask);
    end
    idle_hit(2'd3);
    vectors++;
    if (active_mask !== 4'b0111) begin
      miscompares++;
      $display("FAIL full_hit3: mask=%b, want 0111", active_mask);
    end
    run_frame(0, 0, 2'd0);
    vectors++;
    if (active_mask !== 4'b0111) begin
      miscompares++;
      $display("FAIL fire_pend_cleared: mask=%b, want 0111", active_mask);
    end
    pulse_fire();
    run_frame(0, 0, 2'd0);
    vectors++;
    if (active_mask !== 4'b1111 || slot_x(3) !== 10'd10 || slot_y(3) !== 10'd42) begin
      miscompares++;
      $display("FAIL full_refill: mask=%b x3=%0d y3=%0d, want 1111 10 42", active_mask, slot_x(3), slot_y(3));
    end
  endtask

  initial begin
    Reset = 1'b1; frame_clk = 1'b0; fire = 1'b0; hit_valid = 1'b0; hit_idx = '0;
    PlayerX = '0; PlayerY = '0; DrawX = '0; DrawY = '0;
    test_reset();
    test_spawn();
    test_reset_mid_move();
    test_cooldown();
    test_retire();
    test_hit();
    test_full();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
